// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte-stream handshake between host and program loader
interface prog_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a counted little-endian word image from a host into program memory
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  prog_loader_if.slave      host,
  output logic              WRITE_INSTRUCTION,
  output logic [31:0]       INS,
  output logic [ADDR_W-1:0] ADDR,
  output logic              INS_MEM_RST,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR
  } state_t;

  localparam logic [10:0] MAX_W = 11'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [9:0]        count_q, count_d;
  logic [10:0]       widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready;
  logic              xfer;
  logic [9:0]        hdr_count;
  logic [10:0]       widx_next;

  assign ready           = (state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA);
  assign host.byte_ready = ready;
  assign xfer            = host.byte_valid && ready;
  assign hdr_count       = {host.byte_in[1:0], count_q[7:0]};
  assign widx_next       = widx_q + 11'd1;
  assign INS             = ins_q;
  assign ADDR            = addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      ins_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      ins_q   <= ins_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    widx_d            = widx_q;
    bidx_d            = bidx_q;
    word_d            = word_q;
    ins_d             = ins_q;
    addr_d            = addr_q;
    WRITE_INSTRUCTION = 1'b0;
    INS_MEM_RST       = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    err               = 1'b0;
    cpu_hold          = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        INS_MEM_RST = 1'b1;
        busy        = 1'b1;
        state_d     = HDR_LO;
      end
      HDR_LO: begin
        busy = 1'b1;
        if (xfer) begin
          count_d[7:0] = host.byte_in;
          state_d      = HDR_HI;
        end
      end
      HDR_HI: begin
        busy = 1'b1;
        if (xfer) begin
          count_d[9:8] = host.byte_in[1:0];
          widx_d       = '0;
          bidx_d       = '0;
          if (hdr_count == 10'd0)              state_d = DONE;
          else if ({1'b0, hdr_count} > MAX_W)  state_d = ERR;
          else                                 state_d = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (xfer) begin
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: word_d[7:0]   = host.byte_in;
            2'd1: word_d[15:8]  = host.byte_in;
            2'd2: word_d[23:16] = host.byte_in;
            default: begin
              // Output registers load here so INS/ADDR are stable for the whole WRITE cycle.
              ins_d   = {host.byte_in, word_q};
              addr_d  = ADDR_W'(widx_q);
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        busy              = 1'b1;
        WRITE_INSTRUCTION = 1'b1;
        widx_d            = widx_next;
        state_d           = (widx_next == {1'b0, count_q}) ? DONE : DATA;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = CLEAR;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase

    // Abort only cancels an active load; the WRITE strobe of this cycle has already been issued.
    if (abort && busy) state_d = ERR;
  end

endmodule
